// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default widths for the fetch controller.
//   fetch_state_e : run-control FSM state encoding (IDLE, RUN, DONE)
//   DEF_PC_W      : default program counter width
//   DEF_IMM_W     : default branch offset width (two's complement)
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  localparam int DEF_PC_W  = 12;
  localparam int DEF_IMM_W = 8;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: purely combinational next-PC arithmetic for the fetch controller.
//   pc              in   PC_W   current fetch address
//   immediate       in   IMM_W  signed branch offset
//   seq_pc          out  PC_W   pc + 1 (low bits)
//   seq_in_range    out  1      pc + 1 still addresses instruction memory
//   branch_pc       out  PC_W   pc + 1 + sext(immediate) (low bits)
//   branch_in_range out  1      branch target lies in [0, 2**PC_W-1]
// IMM_W must not exceed PC_W+1 so the PC_W+2 bit working width holds every target.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int IMM_W = DEF_IMM_W
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [IMM_W-1:0] immediate,
  output logic [PC_W-1:0]  seq_pc,
  output logic             seq_in_range,
  output logic [PC_W-1:0]  branch_pc,
  output logic             branch_in_range
);

  logic [PC_W:0]   seq_full;
  logic [PC_W+1:0] pc_plus1_ext;
  logic [PC_W+1:0] imm_sext;
  logic [PC_W+1:0] target;

  // One extra bit catches the carry out of the last address: no wrap allowed.
  assign seq_full     = {1'b0, pc} + {{PC_W{1'b0}}, 1'b1};
  assign seq_pc       = seq_full[PC_W-1:0];
  assign seq_in_range = ~seq_full[PC_W];

  // Two guard bits: bit PC_W+1 is the sign of the target, bit PC_W flags an
  // overshoot past the top of memory. Plain two's complement addition suffices.
  assign pc_plus1_ext = {1'b0, seq_full};
  assign imm_sext     = {{(PC_W + 2 - IMM_W){immediate[IMM_W-1]}}, immediate};
  assign target       = pc_plus1_ext + imm_sext;

  assign branch_pc       = target[PC_W-1:0];
  assign branch_in_range = (target[PC_W+1:PC_W] == 2'b00);

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: program counter sequencer for the single-issue core.
//   Run control (IDLE -> RUN -> DONE), stall hold, halt detection and branch
//   redirect with a signed offset. Out-of-range fetches end the run with fault.
// Optional feature macro: FETCH_CYCLE_COUNT_EN
//   defined   : cycle_count counts every RUN cycle (stall and final cycle
//               included), saturating at all-ones, cleared when a run starts.
//   undefined : cycle_count is tied to zero and no counter flops exist.
// Ports:
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous active-high reset
//   start        in   1      begin a run (honoured in IDLE or DONE)
//   stall        in   1      hold pc/state/fault this cycle
//   halt_instr   in   1      current instruction is HALT
//   branch_en    in   1      current instruction is a conditional branch
//   zero         in   1      ALU zero flag; branch taken = branch_en & zero
//   immediate    in   IMM_W  signed branch offset
//   pc           out  PC_W   current fetch address
//   fetch_valid  out  1      instruction at pc executes this cycle
//   done         out  1      run finished (halt or fault)
//   fault        out  1      run ended on an out-of-range fetch
//   cycle_count  out  CNT_W  RUN-cycle count (zero when the feature is off)
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              IMM_W    = DEF_IMM_W,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_instr,
  input  logic             branch_en,
  input  logic             zero,
  input  logic [IMM_W-1:0] immediate,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count
);

  fetch_state_e    state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic            fault_reg, fault_next;

  logic [PC_W-1:0] seq_pc;
  logic            seq_in_range;
  logic [PC_W-1:0] branch_pc;
  logic            branch_in_range;
  logic            taken;

  next_pc_calc #(
    .PC_W  (PC_W),
    .IMM_W (IMM_W)
  ) u_next_pc_calc (
    .pc              (pc_reg),
    .immediate       (immediate),
    .seq_pc          (seq_pc),
    .seq_in_range    (seq_in_range),
    .branch_pc       (branch_pc),
    .branch_in_range (branch_in_range)
  );

  assign taken = branch_en & zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= START_PC;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    fault_next = fault_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          pc_next    = START_PC;
          fault_next = 1'b0;
        end
      end
      RUN: begin
        // Priority: stall > halt > taken branch > sequential.
        if (!stall) begin
          if (halt_instr) begin
            state_next = DONE;
            fault_next = 1'b0;
          end else if (taken) begin
            if (branch_in_range) begin
              pc_next = branch_pc;
            end else begin
              state_next = DONE;
              fault_next = 1'b1;
            end
          end else if (seq_in_range) begin
            pc_next = seq_pc;
          end else begin
            // Falling off the end of memory: pc stays on the last address.
            state_next = DONE;
            fault_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = START_PC;
        fault_next = 1'b0;
      end
    endcase
  end

  assign pc          = pc_reg;
  assign fetch_valid = (state_reg == RUN);
  assign done        = (state_reg == DONE);
  assign fault       = fault_reg;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_reg;
  logic             start_accept;

  // A start in IDLE or DONE begins a fresh run, so the count restarts there.
  assign start_accept = start && (state_reg != RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (start_accept) begin
      cnt_reg <= '0;
    end else if ((state_reg == RUN) && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cycle_count = cnt_reg;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed table-driven bench for fetch_controller plus
// hand-written sequences for the top-of-memory boundaries.
module tb_fetch_controller;

`ifdef FETCH_CYCLE_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        halt_instr = 1'b0;
  logic        branch_en = 1'b0;
  logic        zero = 1'b0;
  logic [7:0]  immediate = 8'h00;
  logic [11:0] pc;
  logic        fetch_valid;
  logic        done;
  logic        fault;
  logic [31:0] cycle_count;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_controller dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .halt_instr  (halt_instr),
    .branch_en   (branch_en),
    .zero        (zero),
    .immediate   (immediate),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .done        (done),
    .fault       (fault),
    .cycle_count (cycle_count)
  );

  typedef struct {
    bit          rst, st, stl, hlt, br, z;
    logic [7:0]  imm;
    logic [11:0] exp_pc;
    bit          exp_fv, exp_done, exp_fault;
    logic [31:0] exp_cnt;   // value when the counter feature is enabled
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit st, bit stl, bit hlt, bit br, bit z,
                              logic [7:0] imm, int epc, bit efv, bit edone,
                              bit efault, int ecnt);
    vec_t v;
    v.rst = rst; v.st = st; v.stl = stl; v.hlt = hlt; v.br = br; v.z = z;
    v.imm = imm; v.exp_pc = epc[11:0]; v.exp_fv = efv; v.exp_done = edone;
    v.exp_fault = efault; v.exp_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic drive(bit rst, bit st, bit stl, bit hlt, bit br, bit z, logic [7:0] imm);
    reset = rst; start = st; stall = stl; halt_instr = hlt;
    branch_en = br; zero = z; immediate = imm;
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string tag, int epc, bit efv, bit edone, bit efault, int ecnt);
    $display("[TB] %s pc=%0d fv=%0b done=%0b fault=%0b cnt=%0d",
             tag, pc, fetch_valid, done, fault, cycle_count);
    chk({tag, "_pc"}, {20'd0, pc}, epc);
    chk({tag, "_fv"}, {31'd0, fetch_valid}, {31'd0, efv});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, edone});
    chk({tag, "_fault"}, {31'd0, fault}, {31'd0, efault});
    chk({tag, "_cnt"}, cycle_count, CNT_ON ? ecnt : 0);
  endtask

  // From a fresh start at pc=0, branch +128 thirty-one times to reach pc=3968.
  task automatic climb(string tag);
    for (int k = 1; k <= 31; k++) begin
      drive(0, 0, 0, 0, 1, 1, 8'h7F);
      step();
      tests++;
      if (pc !== 12'(128 * k)) begin
        failures++;
        $display("FAIL %s_climb%0d actual=%0d required=%0d", tag, k, pc, 128 * k);
      end
    end
  endtask

  initial begin
    // Scenario 1: reset, start, sequential fetch (start ignored in RUN).
    vecs.push_back(mk(1,0,0,0,0,0,8'h00, 0,0,0,0, 0));
    vecs.push_back(mk(0,1,0,0,0,0,8'h00, 0,1,0,0, 0));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 1,1,0,0, 1));
    vecs.push_back(mk(0,1,0,0,0,0,8'h00, 2,1,0,0, 2));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 3,1,0,0, 3));
    // Scenario 2: branch back by 3 from pc=5, then not-taken at pc=5.
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 4,1,0,0, 4));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 5,1,0,0, 5));
    vecs.push_back(mk(0,0,0,0,1,1,8'hFD, 3,1,0,0, 6));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 4,1,0,0, 7));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 5,1,0,0, 8));
    vecs.push_back(mk(0,0,0,0,1,0,8'hFD, 6,1,0,0, 9));
    // Scenario 3: reach pc=4, stall over taken branch (and halt), then +2.
    vecs.push_back(mk(0,0,0,0,1,1,8'hFD, 4,1,0,0, 10));
    vecs.push_back(mk(0,0,1,0,1,1,8'hFD, 4,1,0,0, 11));
    vecs.push_back(mk(0,0,1,1,1,1,8'hFD, 4,1,0,0, 12));
    vecs.push_back(mk(0,0,0,0,1,1,8'h02, 7,1,0,0, 13));
    // Scenario 4: reach pc=2, branch -128 faults; DONE holds; restart.
    vecs.push_back(mk(0,0,0,0,1,1,8'hFA, 2,1,0,0, 14));
    vecs.push_back(mk(0,0,0,0,1,1,8'h80, 2,0,1,1, 15));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 2,0,1,1, 15));
    vecs.push_back(mk(0,0,0,1,1,1,8'h02, 2,0,1,1, 15));
    vecs.push_back(mk(0,1,0,0,0,0,8'h00, 0,1,0,0, 0));
    // Scenario 5: stall-free run 0..7 then halt.
    for (int p = 1; p <= 7; p++) vecs.push_back(mk(0,0,0,0,0,0,8'h00, p,1,0,0, p));
    vecs.push_back(mk(0,0,0,1,0,0,8'h00, 7,0,1,0, 8));
    // Scenario 6: run to pc=9, reset with start, then start again.
    vecs.push_back(mk(0,1,0,0,0,0,8'h00, 0,1,0,0, 0));
    for (int p = 1; p <= 9; p++) vecs.push_back(mk(0,0,0,0,0,0,8'h00, p,1,0,0, p));
    vecs.push_back(mk(1,1,0,0,0,0,8'h00, 0,0,0,0, 0));
    vecs.push_back(mk(0,1,0,0,0,0,8'h00, 0,1,0,0, 0));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 1,1,0,0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].stl, vecs[i].hlt,
            vecs[i].br, vecs[i].z, vecs[i].imm);
      step();
      chk_all($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_fv,
              vecs[i].exp_done, vecs[i].exp_fault, vecs[i].exp_cnt);
    end

    // Sequence A: branch target exactly 2**PC_W (one past the end) faults.
    drive(1,0,0,0,0,0,8'h00); step();
    drive(0,1,0,0,0,0,8'h00); step();
    chk_all("a_start", 0, 1, 0, 0, 0);
    climb("a");
    drive(0,0,0,0,1,1,8'h7F); step();
    chk_all("a_over", 3968, 0, 1, 1, 32);

    // Sequence B: branch to the last address is legal; sequential past it faults.
    drive(0,1,0,0,0,0,8'h00); step();
    chk_all("b_start", 0, 1, 0, 0, 0);
    climb("b");
    drive(0,0,0,0,1,1,8'h7E); step();
    chk_all("b_last", 4095, 1, 0, 0, 32);
    drive(0,0,1,0,0,0,8'h00); step();
    chk_all("b_stall", 4095, 1, 0, 0, 33);
    drive(0,0,0,0,0,0,8'h00); step();
    chk_all("b_wrap", 4095, 0, 1, 1, 34);
    drive(0,0,0,0,0,0,8'h00); step();
    chk_all("b_hold", 4095, 0, 1, 1, 34);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
